// File: rtl/cotm32_trap_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | cotm32_trap_ctrl: M-mode trap sequencer and owner of mtvec/mepc/mcause/mtval|
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module cotm32_trap_ctrl #(
  parameter int               MXLEN       = 32,
  parameter logic [MXLEN-1:0] RESET_MTVEC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exc_valid,
  input  logic [MXLEN-1:0] exc_cause,
  input  logic [MXLEN-1:0] exc_pc,
  input  logic [MXLEN-1:0] exc_tval,
  input  logic             mret_valid,
  input  logic [1:0]       csr_op,
  input  logic [11:0]      csr_addr,
  input  logic [MXLEN-1:0] csr_wdata,
  output logic [MXLEN-1:0] csr_rdata,
  output logic             csr_illegal,
  output logic             stall,
  output logic             redirect_valid,
  output logic [MXLEN-1:0] redirect_pc
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SAVE     = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_RW   = 2'd1;
  localparam logic [1:0] OP_RS   = 2'd2;
  localparam logic [1:0] OP_RC   = 2'd3;

  localparam logic [11:0] ADDR_MTVEC  = 12'h305;
  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;
  localparam logic [11:0] ADDR_MTVAL  = 12'h343;

  localparam logic [MXLEN-1:0] C_ALIGN_MASK = {{(MXLEN-2){1'b1}}, 2'b00};

  logic [1:0]       r_state;
  logic [MXLEN-1:0] r_mtvec, r_mepc, r_mcause, r_mtval;
  logic [MXLEN-1:0] r_cap_cause, r_cap_pc, r_cap_tval;
  logic [MXLEN-1:0] r_redirect_pc;

  logic             w_legal;
  logic [MXLEN-1:0] w_old;
  logic [MXLEN-1:0] w_new;
  logic             w_csr_we;

  always_comb begin
    w_legal = 1'b1;
    w_old   = '0;
    case (csr_addr)
      ADDR_MTVEC:  w_old = r_mtvec;
      ADDR_MEPC:   w_old = r_mepc;
      ADDR_MCAUSE: w_old = r_mcause;
      ADDR_MTVAL:  w_old = r_mtval;
      default:     w_legal = 1'b0;
    endcase

    case (csr_op)
      OP_RW:   w_new = csr_wdata;
      OP_RS:   w_new = w_old | csr_wdata;
      OP_RC:   w_new = w_old & ~csr_wdata;
      default: w_new = w_old;
    endcase

    csr_illegal = (csr_op != OP_NONE) && !w_legal;
    csr_rdata   = ((csr_op != OP_NONE) && w_legal) ? w_old : '0;
    // Any trap or mret in the same cycle wins over the CSR instruction.
    w_csr_we    = (r_state == ST_IDLE) && (csr_op != OP_NONE) && w_legal &&
                  !exc_valid && !mret_valid;
  end

  assign stall          = (r_state != ST_IDLE);
  assign redirect_valid = (r_state == ST_REDIRECT);
  assign redirect_pc    = r_redirect_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_mtvec       <= RESET_MTVEC & C_ALIGN_MASK;
      r_mepc        <= '0;
      r_mcause      <= '0;
      r_mtval       <= '0;
      r_cap_cause   <= '0;
      r_cap_pc      <= '0;
      r_cap_tval    <= '0;
      r_redirect_pc <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (exc_valid) begin
            r_cap_cause <= exc_cause;
            r_cap_pc    <= exc_pc;
            r_cap_tval  <= exc_tval;
            r_state     <= ST_SAVE;
          end else if (mret_valid) begin
            r_redirect_pc <= r_mepc;
            r_state       <= ST_REDIRECT;
          end else if (w_csr_we) begin
            case (csr_addr)
              ADDR_MTVEC:  r_mtvec  <= w_new & C_ALIGN_MASK;
              ADDR_MEPC:   r_mepc   <= w_new & C_ALIGN_MASK;
              ADDR_MCAUSE: r_mcause <= w_new;
              ADDR_MTVAL:  r_mtval  <= w_new;
              default: ;
            endcase
          end
        end
        ST_SAVE: begin
          // Direct mode only: the vector base is the whole trap target.
          r_mepc        <= r_cap_pc & C_ALIGN_MASK;
          r_mcause      <= r_cap_cause;
          r_mtval       <= r_cap_tval;
          r_redirect_pc <= r_mtvec & C_ALIGN_MASK;
          r_state       <= ST_REDIRECT;
        end
        ST_REDIRECT: r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cotm32_trap_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_cotm32_trap_ctrl: randomized bench with transaction-level CSR model     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_cotm32_trap_ctrl;

  localparam logic [31:0] RST_MTVEC = 32'h0000_0103;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_valid;
  logic [31:0] exc_cause, exc_pc, exc_tval;
  logic        mret_valid;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  cotm32_trap_ctrl #(.MXLEN(32), .RESET_MTVEC(RST_MTVEC)) dut (
    .clk(clk), .rst_n(rst_n),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_valid(mret_valid),
    .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: CSR bank indexed mtvec, mepc, mcause, mtval; last redirect target.
  logic [31:0] m_csr [4];
  logic [31:0] m_rpc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [11:0] a);
    case (a)
      12'h305: return 0;
      12'h341: return 1;
      12'h342: return 2;
      12'h343: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_csr[0] = RST_MTVEC & ~32'h3;
    m_csr[1] = 0;
    m_csr[2] = 0;
    m_csr[3] = 0;
    m_rpc    = 0;
  endtask

  task automatic clear_inputs();
    exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0;
    mret_valid = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
  endtask

  task automatic junk_inputs();
    exc_valid  = 1'($urandom_range(0, 1));
    exc_cause  = $urandom; exc_pc = $urandom; exc_tval = $urandom;
    mret_valid = 1'($urandom_range(0, 1));
    csr_op     = 2'($urandom_range(0, 3));
    csr_addr   = 12'h341 + 12'($urandom_range(0, 2));
    csr_wdata  = $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request in an IDLE cycle, followed by whatever sequence it starts.
  task automatic issue(input bit exc, input bit mret, input logic [1:0] op,
                       input logic [11:0] addr, input logic [31:0] wd,
                       input logic [31:0] cause, input logic [31:0] pc,
                       input logic [31:0] tval);
    int i;
    logic [31:0] old;
    logic [31:0] nv;
    exc_valid = exc; mret_valid = mret;
    exc_cause = cause; exc_pc = pc; exc_tval = tval;
    csr_op = op; csr_addr = addr; csr_wdata = wd;
    #4;
    check("stall_idle", stall, 0);
    check("rv_idle", redirect_valid, 0);
    check("rpc_hold", redirect_pc, m_rpc);
    i = idx_of(addr);
    check("illegal", csr_illegal, (op != 0 && i < 0));
    check("rdata", csr_rdata, (op != 0 && i >= 0) ? m_csr[i] : 32'h0);
    step();
    if (exc) begin
      m_csr[1] = pc & ~32'h3;
      m_csr[2] = cause;
      m_csr[3] = tval;
      junk_inputs();
      #4;
      check("stall_save", stall, 1);
      check("rv_save", redirect_valid, 0);
      step();
      junk_inputs();
      #4;
      m_rpc = m_csr[0];
      check("stall_redir", stall, 1);
      check("rv_trap", redirect_valid, 1);
      check("rpc_trap", redirect_pc, m_rpc);
      step();
    end else if (mret) begin
      junk_inputs();
      #4;
      m_rpc = m_csr[1];
      check("stall_mret", stall, 1);
      check("rv_mret", redirect_valid, 1);
      check("rpc_mret", redirect_pc, m_rpc);
      step();
    end else if (op != 0 && i >= 0) begin
      old = m_csr[i];
      if (op == 2'd1)      nv = wd;
      else if (op == 2'd2) nv = old | wd;
      else                 nv = old & ~wd;
      if (i <= 1) nv = nv & ~32'h3;
      m_csr[i] = nv;
    end
    clear_inputs();
  endtask

  task automatic csr_rd(input logic [11:0] addr);
    issue(0, 0, 2'd2, addr, 0, 0, 0, 0);
  endtask

  task automatic read_all();
    csr_rd(12'h305); csr_rd(12'h341); csr_rd(12'h342); csr_rd(12'h343);
  endtask

  initial begin
    logic [31:0] r;
    logic [11:0] a;
    clear_inputs();
    model_reset();
    rst_n = 0;
    #2;
    check("rst_stall", stall, 0);
    check("rst_rv", redirect_valid, 0);
    check("rst_rpc", redirect_pc, 0);
    step(); step();
    rst_n = 1;
    step();

    // Reset values, RS with zero leaves them intact.
    read_all();

    // Trap entry with unaligned vector base and PC.
    issue(0, 0, 2'd1, 12'h305, 32'h8000_0103, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 32'd2, 32'h0000_0046, 32'hDEAD_BEEF);
    read_all();

    // RS then RC on mcause.
    issue(0, 0, 2'd1, 12'h342, 32'h30, 0, 0, 0);
    issue(0, 0, 2'd2, 12'h342, 32'h0F, 0, 0, 0);
    issue(0, 0, 2'd3, 12'h342, 32'h21, 0, 0, 0);
    csr_rd(12'h342);

    // Exception beats a same-cycle CSR write.
    issue(1, 0, 2'd1, 12'h341, 32'h1234, 32'd11, 32'h0000_5557, 32'h0);
    read_all();

    // mret returns to mepc without touching CSRs; mret beats a CSR write.
    issue(0, 0, 2'd1, 12'h341, 32'h0000_2000, 0, 0, 0);
    issue(0, 1, 2'd1, 12'h342, 32'hFFFF_FFFF, 0, 0, 0);
    read_all();

    // Unimplemented address.
    issue(0, 0, 2'd1, 12'h300, 32'hFFFF_FFFF, 0, 0, 0);
    read_all();

    // Reset during SAVE aborts the trap.
    exc_valid = 1; exc_cause = 32'd7; exc_pc = 32'h0000_0900; exc_tval = 32'h55;
    step();
    clear_inputs();
    #2;
    rst_n = 0;
    #1;
    check("abort_stall", stall, 0);
    check("abort_rv", redirect_valid, 0);
    check("abort_rpc", redirect_pc, 0);
    model_reset();
    step();
    rst_n = 1;
    step();
    read_all();

    for (int k = 0; k < 400; k++) begin
      r = $urandom;
      case ($urandom_range(0, 5))
        0: a = 12'h305;
        1: a = 12'h341;
        2: a = 12'h342;
        3: a = 12'h343;
        4: a = 12'h300;
        default: a = r[11:0];
      endcase
      case ($urandom_range(0, 9))
        0:       issue(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom,
                       $urandom, $urandom, $urandom);
        1:       issue(0, 1, 2'($urandom_range(0, 3)), a, $urandom, 0, 0, 0);
        default: issue(0, 0, 2'($urandom_range(0, 3)), a, $urandom, 0, 0, 0);
      endcase
    end
    read_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
